// File: rtl/qbus_responder.sv
// qbus_responder: single-window Q-bus slave that turns a decoded bus cycle
// into a one-cycle memory access, then answers the master with RPLY.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset (ignores ce)
//   ce                    clock enable; all registers hold while low
//   addr_i, data_i        bus address (with SYNC) and write data (with DOUT)
//   data_o                read data, zero outside REPLY of a read (wired-OR safe)
//   SYNC, DIN, DOUT, WTBT master cycle, read strobe, write strobe, byte op
//   RPLY                  registered reply, high exactly in REPLY
//   sel                   cycle owned (ACCESS, WAIT or REPLY)
//   mem_addr, mem_be      latched word address and byte enables
//   mem_rd, mem_wr        one-ce-cycle memory strobes, issued in ACCESS
//   mem_wdata, mem_rdata  latched write data / synchronous read data
//   state_dbg             current FSM state for observation
//
// Handshake: the master opens a cycle with SYNC and a DIN or DOUT strobe;
// this block answers with RPLY and keeps it up for as long as SYNC stays
// high. Dropping SYNC at any point ends (or aborts) the cycle on the next
// ce edge. A request is only taken from IDLE.
module qbus_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'o100000,
    parameter logic [15:0] ADDR_MASK   = 16'o140000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] addr_i,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    input  logic        SYNC,
    input  logic        DIN,
    input  logic        DOUT,
    input  logic        WTBT,
    output logic        RPLY,
    output logic        sel,
    output logic [14:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_REPLY  = 2'd3
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q;
    logic        rply_q;
    logic [15:0] data_q;
    logic [14:0] addr_q;
    logic [1:0]  be_q;
    logic [15:0] wdata_q;

    logic        hit;
    logic        request;
    logic [1:0]  be_new;

    assign hit     = ((addr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
    assign request = SYNC & (DIN | DOUT) & hit;

    // Reads always move the full word; byte writes pick the lane by addr[0].
    assign be_new = (DIN || !WTBT) ? 2'b11 : (addr_i[0] ? 2'b10 : 2'b01);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (request) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (!SYNC) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = WS;
                end
            end
            S_WAIT: begin
                if (!SYNC)            state_d = S_IDLE;
                else if (cnt_q == 4'd0) state_d = S_REPLY;
                else                  cnt_d = cnt_q - 4'd1;
            end
            S_REPLY: begin
                if (!SYNC) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            rply_q  <= 1'b0;
            data_q  <= 16'h0000;
            addr_q  <= 15'd0;
            be_q    <= 2'b00;
            wdata_q <= 16'h0000;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rply_q  <= (state_d == S_REPLY);
            if (state_q == S_IDLE && request) begin
                addr_q  <= addr_i[15:1];
                rd_q    <= DIN;   // DIN wins when both strobes are up
                be_q    <= be_new;
                wdata_q <= data_i;
            end
            // mem_rdata has been stable since the cycle after mem_rd.
            if (state_q == S_WAIT && state_d == S_REPLY)
                data_q <= rd_q ? mem_rdata : 16'h0000;
            else if (state_d != S_REPLY)
                data_q <= 16'h0000;
        end
    end

    // Strobes are gated by reset_n so a reset edge never issues an access.
    assign mem_rd    = ce & reset_n & (state_q == S_ACCESS) & rd_q;
    assign mem_wr    = ce & reset_n & (state_q == S_ACCESS) & ~rd_q;
    assign RPLY      = rply_q;
    assign sel       = (state_q != S_IDLE);
    assign data_o    = data_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_qbus_responder.sv
module tb_qbus_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce0 = 1'b0;
    logic        ce3 = 1'b0;
    logic [15:0] addr_i = '0;
    logic [15:0] data_i = '0;
    logic        sync = 1'b0, din = 1'b0, dout = 1'b0, wtbt = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] mem_val = '0;

    logic [15:0] data_o0, data_o3, mem_wdata0, mem_wdata3;
    logic        rply0, rply3, sel0, sel3, mem_rd0, mem_rd3, mem_wr0, mem_wr3;
    logic [14:0] mem_addr0, mem_addr3;
    logic [1:0]  mem_be0, mem_be3, state0, state3;

    int checks = 0;
    int failures = 0;
    int which_g = 0;

    always #5 clk = ~clk;

    qbus_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .ce(ce0), .addr_i(addr_i), .data_i(data_i),
        .data_o(data_o0), .SYNC(sync), .DIN(din), .DOUT(dout), .WTBT(wtbt),
        .RPLY(rply0), .sel(sel0), .mem_addr(mem_addr0), .mem_rd(mem_rd0),
        .mem_wr(mem_wr0), .mem_be(mem_be0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata), .state_dbg(state0)
    );

    qbus_responder #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .ce(ce3), .addr_i(addr_i), .data_i(data_i),
        .data_o(data_o3), .SYNC(sync), .DIN(din), .DOUT(dout), .WTBT(wtbt),
        .RPLY(rply3), .sel(sel3), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
        .mem_wr(mem_wr3), .mem_be(mem_be3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata), .state_dbg(state3)
    );

    // Synchronous memory model: returns the word chosen by the current test.
    always @(posedge clk) if (mem_rd0 || mem_rd3) mem_rdata <= mem_val;

    // Outputs of the instance under test.
    logic        o_rply, o_sel, o_rd, o_wr;
    logic [15:0] o_data, o_wdata;
    logic [14:0] o_addr;
    logic [1:0]  o_be;
    assign o_rply  = which_g ? rply3      : rply0;
    assign o_sel   = which_g ? sel3       : sel0;
    assign o_rd    = which_g ? mem_rd3    : mem_rd0;
    assign o_wr    = which_g ? mem_wr3    : mem_wr0;
    assign o_data  = which_g ? data_o3    : data_o0;
    assign o_wdata = which_g ? mem_wdata3 : mem_wdata0;
    assign o_addr  = which_g ? mem_addr3  : mem_addr0;
    assign o_be    = which_g ? mem_be3    : mem_be0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ce(input int which, input logic v);
        if (which == 1) ce3 = v; else ce0 = v;
    endtask

    function automatic logic cur_ce(input int which);
        return (which == 1) ? ce3 : ce0;
    endfunction

    // Transaction-level model: a hit request is accepted on the first ce edge,
    // RPLY rises WS+2 ce edges later, and any ce edge with SYNC low while the
    // cycle is owned returns to idle. Called and returns on a negedge.
    task automatic run_txn(input int which, input logic [15:0] a, input logic din_v,
                           input logic dout_v, input logic wtbt_v, input logic [15:0] wd,
                           input logic [15:0] rv, input int ce_mode, input int abort_at,
                           input int hold);
        int ws, edges, cyc;
        bit done, hit, rd, e_rply, e_sel;
        logic [1:0] e_be;
        ws = (which == 1) ? 3 : 0;
        which_g = which;
        edges = 0; cyc = 0; done = 0;
        hit = ((a & 16'o140000) == 16'o100000);
        rd = din_v;
        e_be = (din_v || !wtbt_v) ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
        addr_i = a; din = din_v; dout = dout_v; wtbt = wtbt_v; data_i = wd;
        mem_val = rv; sync = 1'b1;
        set_ce(which, (ce_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cur_ce(which)) begin
                if (edges > 0 && !sync) done = 1;
                else if (edges > 0 || (sync && hit && (din_v || dout_v))) edges++;
            end
            e_rply = !done && (edges >= ws + 3);
            e_sel  = !done && (edges > 0);
            check("rply", 16'(o_rply), 16'(e_rply));
            check("sel", 16'(o_sel), 16'(e_sel));
            check("data_o", o_data, (e_rply && rd) ? rv : 16'h0000);
            check("mem_rd", 16'(o_rd), 16'(!done && edges == 1 && cur_ce(which) && rd));
            check("mem_wr", 16'(o_wr), 16'(!done && edges == 1 && cur_ce(which) && !rd));
            if (!done && edges == 1) begin
                check("mem_addr", 16'(o_addr), 16'(a[15:1]));
                check("mem_be", 16'(o_be), 16'(e_be));
                if (!rd) check("mem_wdata", o_wdata, wd);
            end
            if (edges == 0 && cyc >= 21) done = 1;
            if (!done) begin
                if (edges == 0 && cyc == 20) sync = 1'b0;
                if (abort_at > 0 && edges >= abort_at) sync = 1'b0;
                if (edges >= ws + 3 + hold) sync = 1'b0;
                case (ce_mode)
                    1:       set_ce(which, !cur_ce(which));
                    2:       set_ce(which, 1'($urandom_range(0, 1)));
                    default: set_ce(which, 1'b1);
                endcase
            end
        end
        check("txn_done", 16'(done), 16'd1);
        din = 1'b0; dout = 1'b0; wtbt = 1'b0;
    endtask

    initial begin
        // Reset with ce low: reset must still apply.
        repeat (3) @(negedge clk);
        check("rst_rply0", 16'(rply0), 16'd0);
        check("rst_sel0", 16'(sel0), 16'd0);
        check("rst_data0", data_o0, 16'h0000);
        check("rst_be0", 16'(mem_be0), 16'd0);
        check("rst_addr0", 16'(mem_addr0), 16'd0);
        check("rst_wdata0", mem_wdata0, 16'h0000);
        check("rst_rd0", 16'(mem_rd0), 16'd0);
        check("rst_rply3", 16'(rply3), 16'd0);
        check("rst_sel3", 16'(sel3), 16'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed reads/writes with zero wait states.
        run_txn(0, 16'o100004, 1, 0, 0, 16'h0000, 16'o123456, 0, 0, 1);
        run_txn(0, 16'o100011, 0, 1, 1, 16'o052400, 16'h0000, 0, 0, 2);
        run_txn(0, 16'o100010, 0, 1, 1, 16'o000377, 16'h0000, 0, 0, 0);
        run_txn(0, 16'o100012, 0, 1, 0, 16'o177001, 16'h0000, 0, 0, 0);
        run_txn(0, 16'o100006, 1, 1, 1, 16'h5555, 16'hc3a5, 0, 0, 0);  // both strobes
        run_txn(0, 16'o040000, 1, 0, 0, 16'h0000, 16'h1111, 0, 0, 0);  // miss
        run_txn(0, 16'o100000, 0, 0, 0, 16'h0000, 16'h2222, 0, 0, 0);  // no strobe
        // Back-to-back: next request lands in IDLE right after REPLY.
        run_txn(0, 16'o100100, 1, 0, 0, 16'h0000, 16'h0f0f, 0, 0, 0);
        run_txn(0, 16'o100102, 1, 0, 0, 16'h0000, 16'hf0f0, 0, 0, 0);

        // Three wait states, alternating ce, plus aborts.
        run_txn(1, 16'o100020, 1, 0, 0, 16'h0000, 16'hbeef, 1, 0, 1);
        run_txn(1, 16'o100023, 0, 1, 1, 16'h7e81, 16'h0000, 1, 0, 0);
        run_txn(1, 16'o100002, 1, 0, 0, 16'h0000, 16'h1234, 0, 3, 0);
        run_txn(1, 16'o100004, 0, 1, 0, 16'habcd, 16'h0000, 0, 1, 0);

        // Randomized transactions on both instances.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            int w, ab;
            a = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a = {2'b10, a[13:0]};
            w = $urandom_range(0, 1);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, w ? 5 : 2) : 0;
            run_txn(w, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    2, ab, $urandom_range(0, 3));
        end
        ce0 = 1'b0; ce3 = 1'b0; sync = 1'b0;

        // Reset during REPLY, with ce low.
        which_g = 0;
        @(negedge clk);
        addr_i = 16'o100040; sync = 1'b1; din = 1'b1; mem_val = 16'h9abc; ce0 = 1'b1;
        for (int i = 0; i < 10 && rply0 !== 1'b1; i++) @(negedge clk);
        check("rply_before_reset", 16'(rply0), 16'd1);
        check("data_before_reset", data_o0, 16'h9abc);
        reset_n = 1'b0; ce0 = 1'b0;
        @(negedge clk);
        check("rr_rply", 16'(rply0), 16'd0);
        check("rr_sel", 16'(sel0), 16'd0);
        check("rr_data", data_o0, 16'h0000);
        check("rr_be", 16'(mem_be0), 16'd0);
        check("rr_addr", 16'(mem_addr0), 16'd0);
        check("rr_wdata", mem_wdata0, 16'h0000);
        reset_n = 1'b1; sync = 1'b0; din = 1'b0;
        @(negedge clk);

        // Reset during ACCESS: strobe suppressed on the reset cycle.
        addr_i = 16'o100050; sync = 1'b1; dout = 1'b1; data_i = 16'h4321; ce0 = 1'b1;
        @(negedge clk);
        check("wr_in_access", 16'(mem_wr0), 16'd1);
        reset_n = 1'b0;
        #1;
        check("wr_gated_by_reset", 16'(mem_wr0), 16'd0);
        @(negedge clk);
        check("ra_sel", 16'(sel0), 16'd0);
        check("ra_rply", 16'(rply0), 16'd0);
        check("ra_wdata", mem_wdata0, 16'h0000);
        reset_n = 1'b1; sync = 1'b0; dout = 1'b0; ce0 = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qbus_responder.md
QBUS_RESPONDER -- requirements
Module: qbus_responder

Interface
REQ-001 Parameter BASE_ADDR, default 16'o100000: base of decoded window.
REQ-002 Parameter ADDR_MASK, default 16'o140000: address bits compared against BASE_ADDR.
REQ-003 Parameter WAIT_STATES, default 0, range 0..15: extra ce-cycles inserted before RPLY.
REQ-004 clk  in  1  single clock; all state changes on posedge clk only.
REQ-005 reset_n  in  1  synchronous, active-low reset; sampled on posedge clk regardless of ce.
REQ-006 ce  in  1  clock enable; when low, all registers hold.
REQ-007 addr_i  in  16  bus address, valid while SYNC high.
REQ-008 data_i  in  16  write data from master, valid while DOUT high.
REQ-009 data_o  out  16  read data to master.
REQ-010 SYNC, DIN, DOUT, WTBT  in  1 each  master cycle, read strobe, write strobe, byte op.
REQ-011 RPLY  out  1  reply to DIN or DOUT.
REQ-012 sel  out  1  high while a decoded cycle is owned (ACCESS, WAIT or REPLY).
REQ-013 mem_addr  out  15  latched word address (addr_i[15:1]).
REQ-014 mem_rd, mem_wr  out  1 each  single-cycle memory strobes.
REQ-015 mem_be  out  2  byte enables, [0]=low byte, [1]=high byte.
REQ-016 mem_wdata  out  16  latched write data.
REQ-017 mem_rdata  in  16  synchronous memory read data, valid the cycle after mem_rd.

Function
REQ-018 Hit = (addr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK).
REQ-019 States: IDLE, ACCESS, WAIT, REPLY.
REQ-020 IDLE->ACCESS on ce edge with SYNC & (DIN|DOUT) & hit; latch addr_i, WTBT, DIN/DOUT direction, data_i.
REQ-021 A miss, or SYNC without DIN/DOUT, leaves IDLE; RPLY stays 0.
REQ-022 ACCESS lasts one ce-cycle.
- mem_rd = ce & ACCESS & read; mem_wr = ce & ACCESS & write.
- Strobes are never high outside ACCESS.
REQ-023 ACCESS->WAIT with wait counter loaded to WAIT_STATES.
- WAIT decrements per ce-cycle, exits to REPLY at counter 0.
- WAIT lasts WAIT_STATES+1 ce-cycles.
REQ-024 On WAIT->REPLY of a read, capture mem_rdata into data_o.
REQ-025 RPLY is registered; it is 1 exactly in REPLY.
- WAIT_STATES=0: request edge E0, RPLY high after E2.
REQ-026 REPLY holds while SYNC high; SYNC low sampled -> IDLE, RPLY 0 after that edge.
REQ-027 data_o is 16'h0000 except in REPLY of a read cycle (wired-OR safe).
REQ-028 Writes: WTBT=0 -> mem_be=11; WTBT=1 -> mem_be = addr[0] ? 10 : 01; mem_wdata = data_i unmodified.
REQ-029 Reads ignore WTBT; mem_be=11, full word returned.
REQ-030 Abort: SYNC low in ACCESS or WAIT -> IDLE, no RPLY; a write already strobed is not undone.
REQ-031 A new request seen in IDLE on the cycle after leaving REPLY is accepted; a request is never accepted from REPLY.
REQ-032 DIN and DOUT both high at request: treated as read; no write strobe.
REQ-033 ce low in any state: state, counter and outputs hold; strobes 0.

Reset
REQ-034 reset_n low at posedge clk, any state, ce ignored:
- state=IDLE, RPLY=0, sel=0, data_o=0.
- mem_rd=mem_wr=0, mem_be=00, mem_addr=0, mem_wdata=0, counter=0.
REQ-035 Reset mid-cycle drops RPLY at that edge; no strobe is issued on the reset cycle.

Verification
REQ-036 Read: WAIT_STATES=0, ce=1, SYNC=DIN=1, addr_i=16'o100004, mem_rdata=16'o123456 ->
- mem_rd pulse at mem_addr=15'o40002;
- RPLY=1 two cycles after request sampled, data_o=16'o123456;
- SYNC drop -> RPLY=0 and data_o=0 next edge.
REQ-037 Byte write: SYNC=DOUT=WTBT=1, addr_i=16'o100011, data_i=16'o052400 ->
- one mem_wr, mem_be=10, mem_wdata=16'o052400;
- RPLY until SYNC drops.
REQ-038 Miss: addr_i=16'o040000 read -> RPLY, sel, mem_rd stay 0 for 20 cycles.
REQ-039 WAIT_STATES=3, alternating ce -> RPLY after 5 ce-cycles post-request; no change on ce=0 cycles.
REQ-040 Abort: SYNC drops during WAIT -> IDLE, no RPLY.
- Reset asserted during REPLY -> RPLY=0 and all outputs at reset values on that edge.
